// File: rtl/seq_det_pkg.sv
// seq_det_pkg: elaboration-time helpers that build the KMP transition table
// for moore_seq_detector.
`default_nettype none

package seq_det_pkg;

  localparam int MAX_LEN = 16;

  function automatic int state_w(input int len);
    return $clog2(len + 1);
  endfunction

  // Bit i of the pattern in arrival order (i = 0 is the first bit received).
  function automatic logic pat_bit(input logic [MAX_LEN-1:0] pattern, input int len, input int i);
    logic [MAX_LEN-1:0] sh;
    sh = pattern >> (len - 1 - i);
    return sh[0];
  endfunction

  function automatic int seq_fail(input logic [MAX_LEN-1:0] pattern, input int len);
    int   f;
    logic ok;
    f = 0;
    for (int j = 1; j < MAX_LEN; j++) begin
      if (j < len) begin
        ok = 1'b1;
        for (int m = 0; m < MAX_LEN; m++) begin
          if (m < j && pat_bit(pattern, len, m) != pat_bit(pattern, len, len - j + m)) ok = 1'b0;
        end
        if (ok) f = j;
      end
    end
    return f;
  endfunction

  function automatic int seq_next(input int k_in, input logic b, input logic [MAX_LEN-1:0] pattern,
                                  input int len, input int overlap);
    int   k;
    int   nxt;
    int   idx;
    logic ok;
    logic sb;
    k = k_in;
    if (k >= len) k = (overlap != 0) ? seq_fail(pattern, len) : 0;
    // Longest pattern prefix that is a suffix of (first k pattern bits, b).
    nxt = 0;
    for (int j = 1; j <= MAX_LEN; j++) begin
      if (j <= k + 1) begin
        ok = 1'b1;
        for (int m = 0; m < MAX_LEN; m++) begin
          if (m < j) begin
            idx = k + 1 - j + m;
            sb  = (idx == k) ? b : pat_bit(pattern, len, idx);
            if (sb != pat_bit(pattern, len, m)) ok = 1'b0;
          end
        end
        if (ok) nxt = j;
      end
    end
    return nxt;
  endfunction

endpackage

`default_nettype wire

// File: rtl/seq_match_counter.sv
// seq_match_counter: saturating detection counter with synchronous clear.
`default_nettype none

module seq_match_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && cnt != {CNT_W{1'b1}}) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/moore_seq_detector.sv
// moore_seq_detector: parametrised Moore serial pattern detector with
// KMP fallback, optional overlap, clock-enable and saturating match count.
`default_nettype none

module moore_seq_detector
  import seq_det_pkg::*;
#(
  parameter int             LEN     = 5,
  parameter logic [LEN-1:0] PATTERN = 5'b10001,
  parameter int             OVERLAP = 0,
  parameter int             CNT_W   = 8,
  localparam int            SW      = state_w(LEN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in,
  input  logic             en,
  input  logic             clr,
  output logic             out,
  output logic [CNT_W-1:0] match_cnt,
  output logic [SW-1:0]    state_o
);

  localparam logic [SW-1:0] DET = SW'(LEN);

  logic [SW-1:0] tbl0 [0:LEN];
  logic [SW-1:0] tbl1 [0:LEN];
  logic [SW-1:0] state;
  logic [SW-1:0] next;
  logic          inc;

  // Transition table is constant, folded at elaboration.
  genvar k;
  for (k = 0; k <= LEN; k++) begin : g_tbl
    assign tbl0[k] = SW'(seq_next(k, 1'b0, MAX_LEN'(PATTERN), LEN, OVERLAP));
    assign tbl1[k] = SW'(seq_next(k, 1'b1, MAX_LEN'(PATTERN), LEN, OVERLAP));
  end

  always_comb begin
    next = in ? tbl1[state] : tbl0[state];
    inc  = en && (next == DET);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= '0;
      out   <= 1'b0;
    end else if (en) begin
      state <= next;
      out   <= (next == DET);
    end
  end

  assign state_o = state;

  seq_match_counter #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk(clk),
    .rst(rst),
    .inc(inc),
    .clr(clr),
    .cnt(match_cnt)
  );

endmodule

`default_nettype wire

// File: tb/tb_moore_seq_detector.sv
// tb_moore_seq_detector: directed stimulus with a queue scoreboard across
// three detector configurations sharing one input stream.
`default_nettype none

module tb_moore_seq_detector;

  typedef struct {
    int o;
    int st;
    int cnt;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_bit = 1'b0;
  logic       en = 1'b0;
  logic       clr = 1'b0;

  logic       oa, ob, oc;
  logic [7:0] ca, cb;
  logic [1:0] cc;
  logic [2:0] sa, sb;
  logic [1:0] sc;

  exp_t qa[$];
  exp_t qb[$];
  exp_t qc[$];
  event ev_chk;
  int   n_assert = 0;
  int   n_fail = 0;

  int s1[9]  = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
  int sa1[9] = '{1, 2, 3, 4, 5, 0, 0, 0, 1};
  int ca1[9] = '{0, 0, 0, 0, 1, 1, 1, 1, 1};
  int sb1[9] = '{1, 2, 3, 4, 5, 2, 3, 4, 5};
  int cb1[9] = '{0, 0, 0, 0, 1, 1, 1, 1, 2};
  int sc4[8] = '{1, 2, 3, 3, 3, 3, 3, 3};
  int cc4[8] = '{0, 0, 1, 2, 3, 3, 3, 3};

  always #5 clk = ~clk;

  moore_seq_detector #(.LEN(5), .PATTERN(5'b10001), .OVERLAP(0), .CNT_W(8)) u_a (
    .clk(clk), .rst(rst), .in(in_bit), .en(en), .clr(clr),
    .out(oa), .match_cnt(ca), .state_o(sa)
  );

  moore_seq_detector #(.LEN(5), .PATTERN(5'b10001), .OVERLAP(1), .CNT_W(8)) u_b (
    .clk(clk), .rst(rst), .in(in_bit), .en(en), .clr(clr),
    .out(ob), .match_cnt(cb), .state_o(sb)
  );

  moore_seq_detector #(.LEN(3), .PATTERN(3'b111), .OVERLAP(1), .CNT_W(2)) u_c (
    .clk(clk), .rst(rst), .in(in_bit), .en(en), .clr(clr),
    .out(oc), .match_cnt(cc), .state_o(sc)
  );

  task automatic cmp1(input string name, input int act, input int exp_v);
    n_assert++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d at %0t", name, act, exp_v, $time);
    end
  endtask

  task automatic cmp(input string dut, input exp_t e, input int o, input int st, input int c);
    cmp1({dut, "_out"}, o, e.o);
    cmp1({dut, "_state"}, st, e.st);
    cmp1({dut, "_cnt"}, c, e.cnt);
  endtask

  // Monitor: samples 2 time units after every rising edge or explicit check.
  always begin
    exp_t e;
    @(posedge clk or ev_chk);
    #2;
    if (qa.size() > 0) begin
      e = qa.pop_front();
      cmp("A", e, int'(oa), int'(sa), int'(ca));
    end
    if (qb.size() > 0) begin
      e = qb.pop_front();
      cmp("B", e, int'(ob), int'(sb), int'(cb));
    end
    if (qc.size() > 0) begin
      e = qc.pop_front();
      cmp("C", e, int'(oc), int'(sc), int'(cc));
    end
  end

  task automatic pa(input int o, input int st, input int c);
    exp_t e;
    e.o = o; e.st = st; e.cnt = c;
    qa.push_back(e);
  endtask

  task automatic pb(input int o, input int st, input int c);
    exp_t e;
    e.o = o; e.st = st; e.cnt = c;
    qb.push_back(e);
  endtask

  task automatic pc(input int o, input int st, input int c);
    exp_t e;
    e.o = o; e.st = st; e.cnt = c;
    qc.push_back(e);
  endtask

  // Called 3 units after a rising edge; results land on the next edge.
  task automatic step(input int b, input int e, input int c);
    in_bit = 1'(b);
    en     = 1'(e);
    clr    = 1'(c);
    @(posedge clk);
    #3;
  endtask

  // Reset between edges; outputs must clear before any clock edge.
  task automatic do_reset();
    en  = 1'b0;
    clr = 1'b0;
    rst = 1'b0;
    pa(0, 0, 0);
    pb(0, 0, 0);
    pc(0, 0, 0);
    ->ev_chk;
    #4;
    @(posedge clk);
    #3;
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    @(posedge clk);
    #3;
    do_reset();

    // Same stream, non-overlapping (A) and overlapping (B).
    for (int i = 0; i < 9; i++) begin
      pa((sa1[i] == 5) ? 1 : 0, sa1[i], ca1[i]);
      pb((sb1[i] == 5) ? 1 : 0, sb1[i], cb1[i]);
      step(s1[i], 1, 0);
    end
    do_reset();

    // Eleven ones never match 10001.
    for (int i = 0; i < 11; i++) begin
      pa(0, 1, 0);
      pb(0, 1, 0);
      step(1, 1, 0);
    end
    do_reset();

    // 111 overlapping, 2-bit counter saturation and clear priority.
    for (int i = 0; i < 8; i++) begin
      pc((sc4[i] == 3) ? 1 : 0, sc4[i], cc4[i]);
      step(1, 1, 0);
    end
    pc(1, 3, 0); step(0, 0, 1);
    pc(1, 3, 0); step(1, 1, 1);
    pc(1, 3, 1); step(1, 1, 0);
    pc(0, 0, 1); step(0, 1, 0);
    do_reset();

    // Enable hold mid-pattern, then hold on the detect state.
    pa(0, 1, 0); step(1, 1, 0);
    pa(0, 2, 0); step(0, 1, 0);
    pa(0, 3, 0); step(0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      pa(0, 3, 0);
      step(i % 2, 0, 0);
    end
    pa(0, 4, 0); step(0, 1, 0);
    pa(1, 5, 1); step(1, 1, 0);
    pa(1, 5, 1); step(0, 0, 0);
    pa(1, 5, 1); step(1, 0, 0);

    // Reset mid-pattern discards the partial match.
    pa(0, 1, 1); step(1, 1, 0);
    pa(0, 2, 1); step(0, 1, 0);
    pa(0, 3, 1); step(0, 1, 0);
    pa(0, 4, 1); step(0, 1, 0);
    do_reset();
    pa(0, 0, 0); step(0, 1, 0);
    pa(0, 0, 0); step(0, 1, 0);
    pa(0, 0, 0); step(0, 1, 0);
    pa(0, 1, 0); step(1, 1, 0);
    pa(0, 1, 0); step(1, 1, 0);
    pa(0, 2, 0); step(0, 1, 0);
    pa(0, 3, 0); step(0, 1, 0);
    pa(0, 4, 0); step(0, 1, 0);
    pa(1, 5, 1); step(1, 1, 0);
    // KMP fallback S2 --1--> S1 rather than S0.
    pa(0, 1, 1); step(1, 1, 0);
    pa(0, 2, 1); step(0, 1, 0);
    pa(0, 1, 1); step(1, 1, 0);

    @(posedge clk);
    #3;
    cmp1("scoreboard_drain", qa.size() + qb.size() + qc.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
